// File: rtl/pow_5_sched_pkg.sv
// Shared types and constants for the two-requester arg^5 scheduler.
package pow_5_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL_STEPS = 4;

endpackage

// File: rtl/arb_rr_2.sv
// Two-way round-robin grant with its priority pointer; grants are combinational
// and only issued while enabled.
module arb_rr_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] vld_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (vld_i == 2'b11) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = vld_i;
            end
        end
        // Priority passes to whichever requester was not just served.
        ptr_d = ptr_q;
        if (|gnt_o) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pow_5_shared_sched.sv
// Computes arg^5 mod 2^w for two requesters through one shared multiplier:
// accept loads acc = arg, then four acc*arg steps, then the result is held.
module pow_5_shared_sched
    import pow_5_sched_pkg::*;
#(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_vld,
    input  logic [w-1:0] req0_arg,
    output logic         req0_rdy,
    input  logic         req1_vld,
    input  logic [w-1:0] req1_arg,
    output logic         req1_rdy,
    output logic         res_vld,
    output logic [w-1:0] res,
    output logic         res_id,
    input  logic         res_rdy
);

    localparam logic [1:0] LAST_STEP = 2'(MUL_STEPS - 1);

    state_t       state_q;
    logic [1:0]   cnt_q;
    logic         res_vld_q;
    logic [w-1:0] acc_q;
    logic [w-1:0] arg_q;
    logic         id_q;

    logic [1:0]   gnt;
    logic         accept;
    logic         arb_en;
    logic [w-1:0] arg_sel;
    logic [w-1:0] acc_d;

    // Gating with rst keeps both rdy low for the whole reset pulse.
    assign arb_en  = (state_q == IDLE) && !rst;
    assign accept  = |gnt;
    assign arg_sel = gnt[1] ? req1_arg : req0_arg;
    assign acc_d   = acc_q * arg_q;

    arb_rr_2 u_arb (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (arb_en),
        .vld_i ({req1_vld, req0_vld}),
        .gnt_o (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            res_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= MUL;
                        cnt_q   <= 2'd0;
                    end
                end
                MUL: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAST_STEP) begin
                        state_q   <= DONE;
                        res_vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        state_q   <= IDLE;
                        res_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    res_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; state alone decides their meaning.
    always_ff @(posedge clk) begin
        if (accept) begin
            arg_q <= arg_sel;
            acc_q <= arg_sel;
            id_q  <= gnt[1];
        end else if (state_q == MUL) begin
            acc_q <= acc_d;
        end
    end

    assign req0_rdy = gnt[0];
    assign req1_rdy = gnt[1];
    assign res_vld  = res_vld_q;
    assign res      = acc_q;
    assign res_id   = id_q;

endmodule

// File: tb/tb_pow_5_shared_sched.sv
// Directed scenarios plus random traffic, checked each cycle against a
// transaction-level model of the arg^5 scheduler.
module tb_pow_5_shared_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_vld, req1_vld;
    logic [7:0] req0_arg, req1_arg;
    logic       req0_rdy, req1_rdy;
    logic       res_vld;
    logic [7:0] res;
    logic       res_id;
    logic       res_rdy;

    always #5 clk = ~clk;

    pow_5_shared_sched #(.w(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0_vld (req0_vld),
        .req0_arg (req0_arg),
        .req0_rdy (req0_rdy),
        .req1_vld (req1_vld),
        .req1_arg (req1_arg),
        .req1_rdy (req1_rdy),
        .res_vld  (res_vld),
        .res      (res),
        .res_id   (res_id),
        .res_rdy  (res_rdy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // staged inputs for the next cycle
    logic       d_rst = 1'b1, d_v0 = 1'b0, d_v1 = 1'b0, d_rr = 1'b0;
    logic [7:0] d_a0 = 8'h00, d_a1 = 8'h00;

    // model: at most one job in flight; result visible from done_iter onward
    bit         m_busy = 1'b0;
    bit         m_ptr  = 1'b0;
    int         m_done = 0;
    logic [7:0] m_res  = 8'h00;
    bit         m_id   = 1'b0;
    int         iter   = 0;

    // last observed DUT values, for the literal checks
    logic       o_rdy0, o_rdy1, o_vld, o_id;
    logic [7:0] o_res;

    function automatic logic [7:0] pow5(input logic [7:0] a);
        longint unsigned p;
        p = longint'(a);
        p = p * p * p * p * p;
        return p[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (iter %0d): got %0h expected %0h", name, iter, act, exp);
        end
    endtask

    task automatic step();
        bit g0, g1, ev;
        @(negedge clk);
        rst = d_rst; req0_vld = d_v0; req0_arg = d_a0;
        req1_vld = d_v1; req1_arg = d_a1; res_rdy = d_rr;
        #1;
        if (d_rst) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end
        g0 = 1'b0; g1 = 1'b0;
        if (!d_rst && !m_busy) begin
            if (d_v0 && d_v1) begin
                g0 = (m_ptr == 1'b0);
                g1 = (m_ptr == 1'b1);
            end else begin
                g0 = d_v0;
                g1 = d_v1;
            end
        end
        ev = !d_rst && m_busy && (iter >= m_done);
        chk("req0_rdy", 32'(req0_rdy), 32'(g0));
        chk("req1_rdy", 32'(req1_rdy), 32'(g1));
        chk("res_vld", 32'(res_vld), 32'(ev));
        if (ev) begin
            chk("res", 32'(res), 32'(m_res));
            chk("res_id", 32'(res_id), 32'(m_id));
        end
        o_rdy0 = req0_rdy; o_rdy1 = req1_rdy; o_vld = res_vld; o_res = res; o_id = res_id;
        if (!d_rst) begin
            if (g0 || g1) begin
                m_busy = 1'b1;
                m_done = iter + 5;
                m_res  = pow5(g1 ? d_a1 : d_a0);
                m_id   = g1;
                m_ptr  = g0;
            end else if (ev && d_rr) begin
                m_busy = 1'b0;
            end
        end
        iter++;
    endtask

    // Offer one operand, wait for its result; returns edges from accept to res_vld.
    task automatic do_req(input bit who, input logic [7:0] arg, input bit rr, input bit scramble,
                          output int lat, output logic [7:0] r, output logic id);
        int acc_it;
        bit seen;
        lat = -1; r = 8'h00; id = 1'b0;
        d_rr = rr;
        if (who) begin d_v1 = 1'b1; d_a1 = arg; end
        else     begin d_v0 = 1'b1; d_a0 = arg; end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = who ? o_rdy1 : o_rdy0;
        end
        if (!seen) begin
            chk("accept_timeout", 32'd0, 32'd1);
            d_v0 = 1'b0; d_v1 = 1'b0;
            return;
        end
        acc_it = iter - 1;
        if (!scramble) begin d_v0 = 1'b0; d_v1 = 1'b0; end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (scramble) begin
                if (who) d_a1 = 8'($urandom); else d_a0 = 8'($urandom);
            end
            step();
            seen = o_vld;
        end
        d_v0 = 1'b0; d_v1 = 1'b0;
        if (!seen) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        lat = (iter - 1) - acc_it - 1;
        r = o_res;
        id = o_id;
    endtask

    initial begin
        int lat;
        logic [7:0] r;
        logic id;
        int acc_its[$];
        logic [7:0] rs[$];
        logic ids[$];
        int vld_seen;

        // reset: outputs quiet even with a request pending
        d_rst = 1'b1; d_v0 = 1'b1; d_a0 = 8'h11;
        step(); step();
        chk("rst_rdy0", 32'(o_rdy0), 32'd0);
        chk("rst_res_vld", 32'(o_vld), 32'd0);
        d_rst = 1'b0; d_v0 = 1'b0;
        step();

        // req0, arg 3
        do_req(1'b0, 8'd3, 1'b1, 1'b0, lat, r, id);
        chk("s1_latency", 32'(lat), 32'd4);
        chk("s1_res", 32'(r), 32'hF3);
        chk("s1_id", 32'(id), 32'd0);
        step();

        // req1, arg 4 then 2
        do_req(1'b1, 8'd4, 1'b1, 1'b0, lat, r, id);
        chk("s2a_res", 32'(r), 32'h00);
        chk("s2a_id", 32'(id), 32'd1);
        step();
        do_req(1'b1, 8'd2, 1'b1, 1'b0, lat, r, id);
        chk("s2b_res", 32'(r), 32'h20);
        step();

        // both requesters from reset
        d_rst = 1'b1; step();
        d_rst = 1'b0; d_rr = 1'b1;
        d_v0 = 1'b1; d_a0 = 8'd2; d_v1 = 1'b1; d_a1 = 8'd3;
        for (int i = 0; i < 16; i++) begin
            step();
            if (o_rdy0 || o_rdy1) begin
                acc_its.push_back(iter - 1);
                ids.push_back(o_rdy1);
                if (o_rdy0) d_v0 = 1'b0;
                if (o_rdy1) d_v1 = 1'b0;
            end
            if (o_vld) rs.push_back(o_res);
        end
        d_v0 = 1'b0; d_v1 = 1'b0;
        chk("s3_accepts", 32'(acc_its.size()), 32'd2);
        chk("s3_results", 32'(rs.size()), 32'd2);
        if (acc_its.size() == 2 && rs.size() == 2) begin
            chk("s3_first_id", 32'(ids[0]), 32'd0);
            chk("s3_second_id", 32'(ids[1]), 32'd1);
            chk("s3_first_res", 32'(rs[0]), 32'h20);
            chk("s3_second_res", 32'(rs[1]), 32'hF3);
            chk("s3_spacing", 32'(acc_its[1] - acc_its[0]), 32'd6);
        end
        step();

        // back-pressure in DONE, requester 0 keeps asking meanwhile
        do_req(1'b0, 8'd7, 1'b0, 1'b0, lat, r, id);
        chk("s4_res", 32'(r), 32'hA7);
        d_v0 = 1'b1; d_a0 = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_hold_res", 32'(o_res), 32'hA7);
            chk("s4_hold_vld", 32'(o_vld), 32'd1);
            chk("s4_hold_rdy0", 32'(o_rdy0), 32'd0);
        end
        d_rr = 1'b1; step();
        step();
        chk("s4_idle_rdy0", 32'(o_rdy0), 32'd1);
        d_v0 = 1'b0;
        for (int i = 0; i < 7; i++) step();

        // reset during the second MUL cycle aborts the job
        d_v1 = 1'b1; d_a1 = 8'd9; d_rr = 1'b1;
        step();
        chk("s5_accept", 32'(o_rdy1), 32'd1);
        d_v1 = 1'b0;
        step();
        d_rst = 1'b1; step();
        d_rst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_vld) vld_seen++;
        end
        chk("s5_no_result", 32'(vld_seen), 32'd0);
        do_req(1'b0, 8'd5, 1'b1, 1'b0, lat, r, id);
        chk("s5_res", 32'(r), 32'h35);
        step();

        // operand changes while busy are ignored
        do_req(1'b0, 8'd6, 1'b1, 1'b1, lat, r, id);
        chk("s6_res", 32'(r), 32'h60);
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            d_rst = ($urandom_range(0, 199) == 0);
            d_v0  = $urandom_range(0, 2) != 0;
            d_v1  = $urandom_range(0, 2) != 0;
            d_a0  = 8'($urandom);
            d_a1  = 8'($urandom);
            d_rr  = $urandom_range(0, 1) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
